// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor slice: indexing modes,
// predictor state encoding and the saturating-counter step function.
package bp_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;
  localparam int unsigned CTR_W_MAX    = 4;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_t;

  // Counter width is passed at the call site so one function serves every CTR_W.
  function automatic logic [CTR_W_MAX-1:0] sat_next(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input int unsigned          ctr_w
  );
    logic [CTR_W_MAX-1:0] top;
    top = CTR_W_MAX'((1 << ctr_w) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)  ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating counters with an INIT sweep pointer, one synchronous
// read port and one read-modify-write update port (read sees pre-update data).
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned INIT_VAL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_en,
  output logic             init_last,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [CTR_W-1:0] mem [2**IDX_W];
  logic [IDX_W-1:0] ptr;
  logic [CTR_W-1:0] wr_next;

  assign init_last = init_en && (ptr == '1);
  assign wr_next   = CTR_W'(sat_next(CTR_W_MAX'(mem[wr_idx]), wr_taken, CTR_W));

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= '0;
    else if (init_en) ptr <= ptr + 1'b1;
  end

  // Read and write share the edge, so the read returns the pre-update counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_en)    mem[ptr]    <= CTR_W'(INIT_VAL);
      else if (wr_en) mem[wr_idx] <= wr_next;
      if (rd_en)      rd_ctr      <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal / gshare branch predictor: index hashing, global history,
// INIT/RUN control and registered prediction outputs around the counter table.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned HIST_W   = 6,
  parameter int unsigned MODE     = MODE_GSHARE,
  parameter int unsigned INIT_VAL = (1 << CTR_W) - 1,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned PC_LSB   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] ghr
);

  bp_state_t         state, state_next;
  logic              init_last;
  logic              req_go, upd_go;
  logic [IDX_W-1:0]  req_idx, upd_idx;
  logic [CTR_W-1:0]  rd_ctr;
  logic              s1_valid;
  logic [HIST_W-1:0] s1_hist;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{req_pc, upd_pc};

  assign req_go  = (state == RUN) && req_valid;
  assign upd_go  = (state == RUN) && upd_valid;
  assign req_idx = req_pc[PC_LSB +: IDX_W] ^ ((MODE == MODE_GSHARE) ? IDX_W'(ghr) : '0);
  assign upd_idx = upd_pc[PC_LSB +: IDX_W] ^ ((MODE == MODE_GSHARE) ? IDX_W'(upd_hist) : '0);

  bp_counter_table #(
    .IDX_W    (IDX_W),
    .CTR_W    (CTR_W),
    .INIT_VAL (INIT_VAL)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_en   (state == INIT),
    .init_last (init_last),
    .rd_en     (req_go),
    .rd_idx    (req_idx),
    .rd_ctr    (rd_ctr),
    .wr_en     (upd_go),
    .wr_idx    (upd_idx),
    .wr_taken  (upd_taken)
  );

  always_comb begin
    state_next = state;
    if (state == INIT && init_last) state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      ready      <= 1'b0;
      ghr        <= '0;
      s1_valid   <= 1'b0;
      s1_hist    <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_hist  <= '0;
    end else begin
      state      <= state_next;
      ready      <= (state_next == RUN);
      s1_valid   <= req_go;
      pred_valid <= s1_valid;
      if (req_go) s1_hist <= ghr;
      // Truncating {ghr, taken} to HIST_W also covers the single-bit history case.
      if (upd_go) ghr <= HIST_W'({ghr, upd_taken});
      if (s1_valid) begin
        pred_taken <= rd_ctr[CTR_W-1];
        pred_hist  <= s1_hist;
      end
    end
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised successor of the single 2-bit saturating-counter branch predictor. It holds a table of 2^IDX_W saturating counters, indexed either by PC alone (bimodal) or by PC XOR global history (gshare). It sits between fetch, which issues prediction requests, and the execute/branch-resolution stage, which issues updates. Counter width, table depth, history length, initial counter value and indexing mode are all parameters.

## Interface
- IDX_W, 6, log2 of table depth; valid range 1..12
- CTR_W, 2, counter width in bits; valid range 1..4
- HIST_W, 6, global history length; valid range 1..IDX_W
- MODE, 1, indexing mode: 0 = bimodal, 1 = gshare
- INIT_VAL, 2^CTR_W-1, counter value after init; the default is strongly taken
- PC_W, 32, PC width
- PC_LSB, 2, lowest PC bit used for indexing
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ready  out  1  table initialised; requests and updates are accepted only while ready is high
- req_valid  in  1  prediction request
- req_pc  in  PC_W  branch PC
- pred_valid  out  1  prediction result valid
- pred_taken  out  1  predicted direction
- pred_hist  out  HIST_W  GHR snapshot used for this prediction
- upd_valid  in  1  resolved-branch update
- upd_pc  in  PC_W  PC of the resolved branch
- upd_hist  in  HIST_W  pred_hist value returned with this branch
- upd_taken  in  1  actual direction
- ghr  out  HIST_W  current global history register

## Operation
- Index function:
  - idx(pc,h) = pc[PC_LSB+IDX_W-1:PC_LSB] XOR (MODE ? zero-extended h : 0).
  - Request index: idx(req_pc, ghr).
  - Update index: idx(upd_pc, upd_hist).
- State machine, two states, INIT and RUN:
  - rst_n low: state goes to INIT, sweep pointer goes to 0, ghr goes to 0, ready/pred_valid/pred_taken/pred_hist go to 0.
  - INIT: each cycle writes INIT_VAL to entry[ptr] and increments ptr.
  - After entry 2^IDX_W-1 is written, state goes to RUN and ready goes to 1.
  - req_valid and upd_valid are ignored in INIT: no table or ghr change, pred_valid stays 0.
- RUN, request:
  - pred_taken = entry[idx][CTR_W-1].
  - pred_hist = the ghr value at the request cycle.
- RUN, update, saturating:
  - upd_taken=1: entry increments unless it equals 2^CTR_W-1.
  - upd_taken=0: entry decrements unless it equals 0.
  - ghr <= {ghr[HIST_W-2:0], upd_taken}; for HIST_W=1, ghr <= upd_taken.
- Request and update in the same cycle, any indices: the request reads the pre-update counter and pre-update ghr (read-before-write).
- Counter arithmetic is CTR_W bits wide and never wraps.
- Reset asserted mid-INIT or mid-RUN: immediately restarts INIT from ptr=0. Any in-flight prediction is dropped, so pred_valid goes to 0 on the next edge.

## Timing
- Prediction latency is 1 cycle: a request accepted at edge N gives pred_valid=1 with pred_taken/pred_hist for the cycle after edge N+1.
- pred_valid is a single-cycle pulse per request. Back-to-back requests give back-to-back results, with no stall and no handshake back-pressure.
- An update at edge N is visible to a request sampled at edge N+1.
- After rst_n is released, INIT lasts 2^IDX_W cycles, and ready rises on the following edge.
- pred_taken and pred_hist hold their last values when pred_valid is 0.

## Structure
- Shared package bp_pkg:
  - constants MODE_BIMODAL=0 and MODE_GSHARE=1;
  - state enum {INIT, RUN};
  - function sat_next(ctr, taken) parametrised on CTR_W.
- One natural sub-module, bp_counter_table: counter array, INIT sweep pointer, one read port and one write port with read-before-write semantics.
- The top level holds the index hashing, ghr, the state machine and output registers.

## Test plan
- Init: release rst_n and count cycles. ready must rise after 64 cycles (IDX_W=6). A request at pc=0x100 must then return pred_taken=1 and pred_hist=0.
- Saturation: CTR_W=2, MODE=0, pc=0x40.
  - 5 not-taken updates leave the counter at 0; predict gives 0.
  - 1 taken update gives counter 1; predict still 0.
  - 2 more taken updates give counter 3; predict 1.
  - A 4th taken update leaves it at 3.
- Gshare aliasing: MODE=1.
  - Updates drive ghr to 6'b000011.
  - A request with pc=0x0C (pc[7:2]=3) indexes entry 0; check entry 0's value.
  - With MODE=0, the same request indexes entry 3.
- Simultaneous: same cycle, request pc=0x40 and not-taken update pc=0x40 on a counter at 2. The prediction must be 1. A following request must give 0, and its pred_hist must show the shifted-in 0.
- Reset mid-run: assert rst_n=0 for 1 cycle while requests stream. Required on the next edge: pred_valid=0, ready=0, ghr=0. ready returns after 64 cycles, and all entries read INIT_VAL.
- Ignore during INIT: drive req_valid and upd_valid throughout INIT. Required: no pred_valid pulses, ghr stays 0, and entries equal INIT_VAL afterward.
